// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares the single memory port (MAR/MDR, EN/RW strobes, MFC handshake)
// between the instruction-fetch requester (f_*) and the execute-phase
// load/store requester (e_*). Each granted transfer runs through
// IDLE -> GRANT (address/MDR setup) -> ACCESS (EN high, wait for MFC) -> DONE
// (one-cycle done pulse to the winner). Simultaneous requests are settled
// round-robin: the requester that was not served last wins.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   f_req, f_addr       fetch read request (level) and address
//   f_done, f_rdata     fetch completion pulse and captured read data
//   e_req, e_rw         execute request (level), 1=read 0=write
//   e_addr, e_wdata     execute address and write data
//   e_done, e_rdata     execute completion pulse and captured read data
//   mem_en, mem_rw      memory strobes EN and RW
//   mem_addr, mem_wdata registered MAR and MDR
//   mem_rdata, MFC      memory read data and function-complete handshake
//   grant_f, grant_e    bus ownership, high from GRANT through DONE
//   busy                high whenever the arbiter is not idle
//   timeout_err         (MFC_TIMEOUT_EN only) pulses with done when MFC never came
//
// Build option: define MFC_TIMEOUT_EN to bound the MFC wait to TIMEOUT
// ACCESS cycles. Without it, ACCESS waits indefinitely for MFC.
// All outputs are registered and change only with the state register.

module mem_bus_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_done,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              e_req,
  input  logic              e_rw,
  input  logic [ADDR_W-1:0] e_addr,
  input  logic [DATA_W-1:0] e_wdata,
  output logic              e_done,
  output logic [DATA_W-1:0] e_rdata,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              MFC,
  output logic              grant_f,
  output logic              grant_e,
  output logic              busy
`ifdef MFC_TIMEOUT_EN
  ,
  output logic              timeout_err
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state;
  logic   owner_e;  // current transfer belongs to execute
  logic   last_e;   // execute was the last requester served

`ifdef MFC_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      owner_e   <= 1'b0;
      last_e    <= 1'b1;  // fetch wins the first tie after reset
      mem_en    <= 1'b0;
      mem_rw    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      f_rdata   <= '0;
      e_rdata   <= '0;
      f_done    <= 1'b0;
      e_done    <= 1'b0;
      grant_f   <= 1'b0;
      grant_e   <= 1'b0;
      busy      <= 1'b0;
`ifdef MFC_TIMEOUT_EN
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      // Done and timeout pulses last exactly one cycle.
      f_done <= 1'b0;
      e_done <= 1'b0;
`ifdef MFC_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (f_req || e_req) begin
            state <= GRANT;
            busy  <= 1'b1;
            // Fetch wins when alone, or on a tie if execute went last.
            if (f_req && (!e_req || last_e)) begin
              owner_e  <= 1'b0;
              grant_f  <= 1'b1;
              mem_addr <= f_addr;
              mem_rw   <= 1'b1;
            end else begin
              owner_e   <= 1'b1;
              grant_e   <= 1'b1;
              mem_addr  <= e_addr;
              mem_rw    <= e_rw;
              mem_wdata <= e_wdata;
            end
          end
        end

        GRANT: begin
          state  <= ACCESS;
          mem_en <= 1'b1;
`ifdef MFC_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end

        ACCESS: begin
          if (MFC) begin
            state  <= DONE;
            mem_en <= 1'b0;
            f_done <= !owner_e;
            e_done <= owner_e;
            if (mem_rw) begin
              if (owner_e) e_rdata <= mem_rdata;
              else         f_rdata <= mem_rdata;
            end
          end
`ifdef MFC_TIMEOUT_EN
          // This is the TIMEOUT-th MFC-low cycle: give up without capturing data.
          else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            state       <= DONE;
            mem_en      <= 1'b0;
            f_done      <= !owner_e;
            e_done      <= owner_e;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end

        DONE: begin
          state   <= IDLE;
          grant_f <= 1'b0;
          grant_e <= 1'b0;
          busy    <= 1'b0;
          last_e  <= owner_e;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
// Directed stimulus for mem_bus_arbiter. The stimulus process pushes the
// expected completion of each transfer into a queue; a monitor pops an entry
// on every done pulse and compares port, read data, MAR/MDR/RW and the cycle
// of completion. Per-cycle invariants (exclusive done pulses and grants) and
// a few direct state checks complete the picture.

module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req;
  logic [15:0] f_addr;
  logic        f_done;
  logic [15:0] f_rdata;
  logic        e_req;
  logic        e_rw;
  logic [15:0] e_addr;
  logic [15:0] e_wdata;
  logic        e_done;
  logic [15:0] e_rdata;
  logic        mem_en;
  logic        mem_rw;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        MFC;
  logic        grant_f;
  logic        grant_e;
  logic        busy;
`ifdef MFC_TIMEOUT_EN
  logic        timeout_err;
`endif

  mem_bus_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .f_req     (f_req),
    .f_addr    (f_addr),
    .f_done    (f_done),
    .f_rdata   (f_rdata),
    .e_req     (e_req),
    .e_rw      (e_rw),
    .e_addr    (e_addr),
    .e_wdata   (e_wdata),
    .e_done    (e_done),
    .e_rdata   (e_rdata),
    .mem_en    (mem_en),
    .mem_rw    (mem_rw),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .MFC       (MFC),
    .grant_f   (grant_f),
    .grant_e   (grant_e),
    .busy      (busy)
`ifdef MFC_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          is_e;
    logic [15:0] rdata;
    logic [15:0] addr;
    bit          rw;
    logic [15:0] wdata;
    int          cyc;
    bit          tmo;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_x;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input bit is_e, input logic [15:0] rd, input logic [15:0] ad,
                      input bit rw, input logic [15:0] wd, input int c, input bit t);
    exp_t x;
    x.is_e = is_e; x.rdata = rd; x.addr = ad; x.rw = rw;
    x.wdata = wd; x.cyc = c; x.tmo = t;
    exp_q.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int n, input int budget);
    int seen = 0;
    int k = 0;
    while (seen < n && k < budget) begin
      @(negedge clk);
      k++;
      if (f_done || e_done) seen++;
    end
    chk("done_within_budget", seen, n);
  endtask

  // Monitor: invariants every cycle, scoreboard compare on each done pulse.
  always @(negedge clk) begin
    chk("done_exclusive", {31'b0, f_done && e_done}, 32'd0);
    chk("grant_exclusive", {31'b0, grant_f && grant_e}, 32'd0);
`ifdef MFC_TIMEOUT_EN
    if (!(f_done || e_done)) chk("timeout_err_idle", {31'b0, timeout_err}, 32'd0);
`endif
    if (f_done || e_done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_x = exp_q.pop_front();
        chk("done_port_e", {31'b0, e_done}, {31'b0, mon_x.is_e});
        chk("rdata", {16'b0, mon_x.is_e ? e_rdata : f_rdata}, {16'b0, mon_x.rdata});
        chk("mem_addr", {16'b0, mem_addr}, {16'b0, mon_x.addr});
        chk("mem_rw", {31'b0, mem_rw}, {31'b0, mon_x.rw});
        if (!mon_x.rw) chk("mem_wdata", {16'b0, mem_wdata}, {16'b0, mon_x.wdata});
        if (mon_x.cyc >= 0) chk("done_cycle", cyc, mon_x.cyc);
        chk("grant_at_done", {31'b0, mon_x.is_e ? grant_e : grant_f}, 32'd1);
`ifdef MFC_TIMEOUT_EN
        chk("timeout_err", {31'b0, timeout_err}, {31'b0, mon_x.tmo});
`endif
      end
    end
  end

  initial begin
    #(200000);
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected < 20000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_f;
    logic [15:0] exp_e;
    int n;
    exp_f = 16'h0;
    exp_e = 16'h0;
    rst = 1'b0; f_req = 1'b0; f_addr = '0; e_req = 1'b0; e_rw = 1'b1;
    e_addr = '0; e_wdata = '0; mem_rdata = '0; MFC = 1'b0;

    // Initial reset: every output at zero.
    step(); step();
    @(negedge clk);
    chk("rst_mem_en", {31'b0, mem_en}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_grants", {30'b0, grant_f, grant_e}, 0);
    chk("rst_dones", {30'b0, f_done, e_done}, 0);
    chk("rst_mem_addr", {16'b0, mem_addr}, 0);
    chk("rst_rdata", {f_rdata, e_rdata}, 0);
    step();
    rst = 1'b1;

    // Single fetch read, MFC already high: EN only in n+2, done at n+3.
    mem_rdata = 16'hA5A5; MFC = 1'b1; f_addr = 16'h0010;
    n = cyc;
    exp_f = 16'hA5A5;
    push(1'b0, exp_f, 16'h0010, 1'b1, 16'h0, n + 3, 1'b0);
    f_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("fetch_mem_en_n+%0d", k), {31'b0, mem_en}, {31'b0, k == 2});
    end
    step();
    f_req = 1'b0;

    // Execute read, gives e_rdata a known non-zero value.
    mem_rdata = 16'h5A5A; e_rw = 1'b1; e_addr = 16'h0300;
    exp_e = 16'h5A5A;
    push(1'b1, exp_e, 16'h0300, 1'b1, 16'h0, cyc + 3, 1'b0);
    e_req = 1'b1;
    wait_done(1, 10);
    step();
    e_req = 1'b0;

    // Execute write, MFC rises on the third ACCESS cycle: done at n+5.
    mem_rdata = 16'hDEAD; MFC = 1'b0; e_rw = 1'b0;
    e_addr = 16'h0200; e_wdata = 16'h1234;
    n = cyc;
    push(1'b1, exp_e, 16'h0200, 1'b0, 16'h1234, n + 5, 1'b0);
    e_req = 1'b1;
    repeat (4) step();
    MFC = 1'b1;
    wait_done(1, 10);
    step();
    e_req = 1'b0;
    MFC = 1'b0;

    // Reset in the middle of ACCESS: transfer aborted, no done pulse.
    e_rw = 1'b1; e_addr = 16'h0400;
    e_req = 1'b1;
    step(); step(); step();
    rst = 1'b0;
    e_req = 1'b0;
    step();
    @(negedge clk);
    chk("abort_mem_en_next", {31'b0, mem_en}, 0);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("abort_mem_en", {31'b0, mem_en}, 0);
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_f_rdata", {16'b0, f_rdata}, 0);
    chk("abort_e_rdata", {16'b0, e_rdata}, 0);
    chk("abort_mem_wdata", {16'b0, mem_wdata}, 0);
    chk("abort_grants", {30'b0, grant_f, grant_e}, 0);
    exp_f = 16'h0;
    exp_e = 16'h0;

    // Contention straight after reset: fetch wins first, then f,e,f,e.
    step();
    mem_rdata = 16'h1111; MFC = 1'b1;
    f_addr = 16'h0040; e_addr = 16'h0080; e_rw = 1'b1;
    n = cyc;
    exp_f = 16'h1111;
    exp_e = 16'h1111;
    push(1'b0, exp_f, 16'h0040, 1'b1, 16'h0, n + 3,  1'b0);
    push(1'b1, exp_e, 16'h0080, 1'b1, 16'h0, n + 7,  1'b0);
    push(1'b0, exp_f, 16'h0040, 1'b1, 16'h0, n + 11, 1'b0);
    push(1'b1, exp_e, 16'h0080, 1'b1, 16'h0, n + 15, 1'b0);
    f_req = 1'b1; e_req = 1'b1;
    wait_done(4, 40);
    step();
    f_req = 1'b0; e_req = 1'b0;

    // MFC high only in IDLE/GRANT: ACCESS keeps waiting.
    mem_rdata = 16'h2222; MFC = 1'b1; f_addr = 16'h0060;
    f_req = 1'b1;
    step();
    step();
    MFC = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("early_mfc_mem_en", {31'b0, mem_en}, 1);
      chk("early_mfc_grant_f", {31'b0, grant_f}, 1);
      step();
    end
    exp_f = 16'h2222;
    push(1'b0, exp_f, 16'h0060, 1'b1, 16'h0, cyc + 1, 1'b0);
    MFC = 1'b1;
    wait_done(1, 5);
    step();
    f_req = 1'b0;
    MFC = 1'b0;

`ifdef MFC_TIMEOUT_EN
    // MFC stuck low: timeout after 4 ACCESS cycles, rdata untouched.
    mem_rdata = 16'hFFFF; f_addr = 16'h0070;
    push(1'b0, exp_f, 16'h0070, 1'b1, 16'h0, cyc + 6, 1'b1);
    f_req = 1'b1;
    wait_done(1, 20);
    step();
    f_req = 1'b0;
    @(negedge clk);
    chk("timeout_back_to_idle", {31'b0, busy}, 0);
`endif

    repeat (3) step();
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Arbitrates the single memory port (MAR/MDR path, EN/RW strobes, MFC handshake) between two requesters: instruction fetch (port f_*) and execute-phase load/store (port e_*).
- Sequences each granted transfer through address setup, the memory strobe and MFC wait, then returns a one-cycle done pulse with read data to the winning requester.
- Sits between the fetch/execute control FSMs and the memory model. No requester drives EN/RW directly.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- TIMEOUT, 15, maximum ACCESS cycles to wait for MFC (used only with the optional feature).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset: sampled on the clk rising edge, and rst=0 resets.
- f_req  in  1  fetch read request, level; held until f_done.
- f_addr  in  ADDR_W  fetch address (PC); stable while f_req=1.
- f_done  out  1  one-cycle pulse, fetch transfer complete.
- f_rdata  out  DATA_W  fetch read data; valid when f_done=1 and held until the next fetch done.
- e_req  in  1  execute request, level; held until e_done.
- e_rw  in  1  1=read, 0=write; stable while e_req=1.
- e_addr  in  ADDR_W  execute address.
- e_wdata  in  DATA_W  execute write data.
- e_done  out  1  one-cycle pulse, execute transfer complete.
- e_rdata  out  DATA_W  execute read data; valid when e_done=1 after a read and held until the next execute done.
- mem_en  out  1  memory enable (EN).
- mem_rw  out  1  1=read, 0=write (RW).
- mem_addr  out  ADDR_W  registered address to memory (MAR).
- mem_wdata  out  DATA_W  registered write data (MDR).
- mem_rdata  in  DATA_W  memory read data.
- MFC  in  1  memory function complete.
- grant_f  out  1  fetch owns the bus (GRANT/ACCESS/DONE).
- grant_e  out  1  execute owns the bus.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=0 at an edge):
  - State goes to IDLE. All outputs return to 0, including rdata registers, mem_addr and mem_wdata.
  - The last-served pointer is set to execute, so fetch wins the first tie.
  - Reset mid-transfer aborts it: no done pulse, and mem_en is low from the next cycle.
- States: IDLE, GRANT, ACCESS, DONE (plus the timeout path below). All outputs are Moore, decoded from registered state.
- IDLE:
  - If only one req=1, go to GRANT for that requester.
  - If both are high, round-robin: grant the requester not served last.
  - On entry to GRANT, mem_addr, mem_rw and mem_wdata are latched from the winner. Fetch always has mem_rw=1.
- GRANT:
  - Address/MDR setup cycle: mem_en=0, grant_x=1.
  - Unconditionally go to ACCESS.
- ACCESS:
  - mem_en=1.
  - MFC=1 sampled at an edge → DONE. On that edge, if mem_rw=1, mem_rdata is captured into the winner's rdata register.
  - MFC=0 → stay in ACCESS.
  - MFC high in any other state is ignored.
- DONE:
  - mem_en=0. The winner's done=1 for exactly one cycle. Last-served is updated.
  - Go to IDLE.
  - The requester must deassert req by the next IDLE cycle. A req still high in IDLE counts as a new request.
- Latency: with MFC already high, req seen in IDLE at cycle n gives done at n+3. Each extra MFC-low ACCESS cycle adds 1.
- Back-to-back: with both requesters continuously requesting, grants alternate f,e,f,e. Each transfer occupies at least 4 cycles including IDLE.
- A request arriving outside IDLE is not sampled until IDLE. mem_addr does not change during GRANT/ACCESS/DONE.
- f_done and e_done are never high in the same cycle. grant_f and grant_e are mutually exclusive.

Optional Feature:
- Macro MFC_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT+1) clears on entry to ACCESS and increments each ACCESS cycle with MFC=0.
  - When the counter reaches TIMEOUT with MFC=0, go to DONE with no data capture: rdata is left unchanged.
  - A registered output port timeout_err (1 bit) pulses high in the same DONE cycle. It resets to 0.
  - MFC=1 on the cycle the counter hits TIMEOUT counts as success.
- Not defined: no counter and no timeout_err port; ACCESS waits indefinitely for MFC.

Test Plan:
- Reset: rst=0 for 2 edges mid-ACCESS → mem_en=0, busy=0, no done pulse, f_rdata=0. Then f_req wins a simultaneous first request.
- Single fetch read: f_addr=0x0010, mem_rdata=0xA5A5, MFC held 1 → mem_en high only in cycle n+2, f_done pulse at n+3, f_rdata=0xA5A5, mem_addr=0x0010.
- Execute write: e_rw=0, e_addr=0x0200, e_wdata=0x1234, MFC asserted after 3 ACCESS cycles → mem_rw=0, mem_wdata=0x1234, e_done at n+5, e_rdata unchanged.
- Contention: f_req=e_req=1, re-requesting after each done → grant order f,e,f,e. Done pulses never overlap.
- Early MFC: MFC=1 during IDLE/GRANT only, then 0 in ACCESS → stays in ACCESS, no done.
- MFC_TIMEOUT_EN with TIMEOUT=4: MFC stuck at 0 → timeout_err and f_done pulse together in the DONE cycle after 4 ACCESS cycles, f_rdata unchanged, then IDLE.
